// File: rtl/gnr_attractor_detector.sv
// Drives a gene regulatory network through load / tortoise-hare run / period measurement and reports meet step and period.
// Optional macro GNR_TIMEOUT_EN bounds both counters by MAX_STEPS and reports a timeout result.
module gnr_attractor_detector #(
    parameter int NUM_NODES = 188,
    parameter int CNT_WIDTH = 32,
    parameter int MAX_STEPS = 1048576
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 init_valid,
    output logic                 init_ready,
    input  logic [NUM_NODES-1:0] init_state,
    output logic                 reset_nos,
    output logic [NUM_NODES-1:0] init_out,
    output logic                 start_s0,
    output logic                 start_s1,
    input  logic [NUM_NODES-1:0] s0_vec,
    input  logic [NUM_NODES-1:0] s1_vec,
    output logic                 busy,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CNT_WIDTH-1:0] out_meet,
    output logic [CNT_WIDTH-1:0] out_period,
    output logic                 out_timeout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_PERIOD,
        S_REPORT
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_TWO = CNT_WIDTH'(2);

`ifdef GNR_TIMEOUT_EN
    localparam logic [CNT_WIDTH-1:0] MAX_C = CNT_WIDTH'(MAX_STEPS);
`else
    logic [31:0] unused_max_steps;
    assign unused_max_steps = 32'(MAX_STEPS);
`endif

    state_t                 state_q, state_d;
    logic [NUM_NODES-1:0]   init_out_q, init_out_d;
    logic [CNT_WIDTH-1:0]   step_q, step_d;
    logic [CNT_WIDTH-1:0]   per_q, per_d;
    logic [CNT_WIDTH-1:0]   meet_q, meet_d;
    logic [CNT_WIDTH-1:0]   period_q, period_d;
    logic                   timeout_q, timeout_d;
    logic                   match;
    logic                   hit;
    logic                   limit;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    assign match = (s0_vec == s1_vec);

    always_comb begin
        state_d    = state_q;
        init_out_d = init_out_q;
        step_d     = step_q;
        per_d      = per_q;
        meet_d     = meet_q;
        period_d   = period_q;
        timeout_d  = timeout_q;
        init_ready = 1'b0;
        reset_nos  = 1'b0;
        start_s0   = 1'b0;
        start_s1   = 1'b0;
        hit        = 1'b0;
        limit      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (init_valid) begin
                    init_ready = 1'b1;
                    init_out_d = init_state;
                    state_d    = S_LOAD;
                end
            end
            S_LOAD: begin
                reset_nos = 1'b1;
                step_d    = '0;
                per_d     = '0;
                meet_d    = '0;
                period_d  = '0;
                timeout_d = 1'b0;
                state_d   = S_RUN;
            end
            S_RUN: begin
                // step 1 always matches (both sides at f(x)), so the meet check needs step >= 2
                hit = (step_q >= CNT_TWO) && match;
`ifdef GNR_TIMEOUT_EN
                limit = !hit && (step_q >= MAX_C);
`endif
                start_s0 = !(hit || limit);
                start_s1 = !(hit || limit);
                if (hit) begin
                    meet_d  = step_q;
                    state_d = S_PERIOD;
                end else if (limit) begin
                    meet_d    = step_q;
                    period_d  = '0;
                    timeout_d = 1'b1;
                    state_d   = S_REPORT;
                end else begin
                    step_d = sat_inc(step_q);
                end
            end
            S_PERIOD: begin
                hit = (per_q >= CNT_ONE) && match;
`ifdef GNR_TIMEOUT_EN
                limit = !hit && (per_q >= MAX_C);
`endif
                start_s1 = !(hit || limit);
                if (hit) begin
                    period_d = per_q;
                    state_d  = S_REPORT;
                end else if (limit) begin
                    period_d  = per_q;
                    timeout_d = 1'b1;
                    state_d   = S_REPORT;
                end else begin
                    per_d = sat_inc(per_q);
                end
            end
            S_REPORT: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // abort wins over every transition, including the IDLE accept
        if (clear) begin
            state_d    = S_IDLE;
            init_out_d = init_out_q;
            init_ready = 1'b0;
            reset_nos  = 1'b0;
            start_s0   = 1'b0;
            start_s1   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            init_out_q <= '0;
            step_q     <= '0;
            per_q      <= '0;
            meet_q     <= '0;
            period_q   <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_out_q <= init_out_d;
            step_q     <= step_d;
            per_q      <= per_d;
            meet_q     <= meet_d;
            period_q   <= period_d;
            timeout_q  <= timeout_d;
        end
    end

    assign init_out    = init_out_q;
    assign busy        = (state_q != S_IDLE);
    assign out_valid   = (state_q == S_REPORT);
    assign out_meet    = meet_q;
    assign out_period  = period_q;
`ifdef GNR_TIMEOUT_EN
    assign out_timeout = timeout_q;
`else
    assign out_timeout = 1'b0;
    logic unused_timeout;
    assign unused_timeout = timeout_q;
`endif

endmodule

// File: tb/tb_gnr_attractor_detector.sv
// Directed bench for gnr_attractor_detector with a 4-node behavioural network driven by a lookup table.
module tb_gnr_attractor_detector;

    logic       clk = 1'b0;
    logic       rst;
    logic       clear;
    logic       init_valid;
    logic       init_ready;
    logic [3:0] init_state;
    logic       reset_nos;
    logic [3:0] init_out;
    logic       start_s0;
    logic       start_s1;
    logic [3:0] s0_vec;
    logic [3:0] s1_vec;
    logic       busy;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_meet;
    logic [7:0] out_period;
    logic       out_timeout;

    logic [3:0] fmap [16];
    logic       pass_flag;
    int         n_pass = 0;
    int         n_chk  = 0;

    always #5 clk = ~clk;

    gnr_attractor_detector #(
        .NUM_NODES(4),
        .CNT_WIDTH(8),
        .MAX_STEPS(16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .init_valid (init_valid),
        .init_ready (init_ready),
        .init_state (init_state),
        .reset_nos  (reset_nos),
        .init_out   (init_out),
        .start_s0   (start_s0),
        .start_s1   (start_s1),
        .s0_vec     (s0_vec),
        .s1_vec     (s1_vec),
        .busy       (busy),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_meet   (out_meet),
        .out_period (out_period),
        .out_timeout(out_timeout)
    );

    // network: hare steps every enable, tortoise on every other enable starting with the first
    always_ff @(posedge clk) begin
        if (reset_nos) begin
            s0_vec    <= init_out;
            s1_vec    <= init_out;
            pass_flag <= 1'b1;
        end else begin
            if (start_s1) s1_vec <= fmap[s1_vec];
            if (start_s0) begin
                if (pass_flag) s0_vec <= fmap[s0_vec];
                pass_flag <= ~pass_flag;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic set_identity();
        for (int i = 0; i < 16; i++) fmap[i] = 4'(i);
    endtask

    task automatic run_job(input logic [3:0] x, input int exp_meet, input int exp_per,
                           input int exp_to, input int exp_lat, input int hold);
        int cyc;
        @(negedge clk);
        init_valid = 1'b1;
        init_state = x;
        #1 chk("init_ready", 32'(init_ready), 1);
        @(negedge clk);
        init_valid = 1'b0;
        chk("load_reset_nos", 32'(reset_nos), 1);
        chk("load_init_out", 32'(init_out), 32'(x));
        chk("load_busy", 32'(busy), 1);
        chk("load_init_ready", 32'(init_ready), 0);
        cyc = 0;
        while (!out_valid && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("latency", 32'(cyc), 32'(exp_lat));
        chk("out_meet", 32'(out_meet), 32'(exp_meet));
        chk("out_period", 32'(out_period), 32'(exp_per));
        chk("out_timeout", 32'(out_timeout), 32'(exp_to));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", 32'(out_valid), 1);
            chk("hold_meet", 32'(out_meet), 32'(exp_meet));
            chk("hold_period", 32'(out_period), 32'(exp_per));
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("post_valid", 32'(out_valid), 0);
        chk("post_busy", 32'(busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, observed no finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        rst        = 1'b1;
        clear      = 1'b0;
        init_valid = 1'b0;
        init_state = '0;
        out_ready  = 1'b0;
        set_identity();

        #12;
        chk("reset_outs", 32'({init_ready, reset_nos, init_out, start_s0, start_s1,
                               busy, out_valid, out_timeout}), 0);
        chk("reset_meet", 32'(out_meet), 0);
        chk("reset_period", 32'(out_period), 0);
        @(negedge clk);
        rst = 1'b0;

        // fixed point: f(5) = 5
        set_identity();
        run_job(4'd5, 2, 1, 0, 6, 0);

        // pure 3-cycle orbit 1 -> 2 -> 3 -> 1, with 5 cycles of backpressure
        set_identity();
        fmap[1] = 4'd2; fmap[2] = 4'd3; fmap[3] = 4'd1;
        run_job(4'd1, 6, 3, 0, 12, 5);

        // transient of two: 8 -> 9 -> 10, 10 fixed
        set_identity();
        fmap[8] = 4'd9; fmap[9] = 4'd10;
        run_job(4'd8, 3, 1, 0, 7, 0);

        // 16-cycle orbit over all states
        for (int i = 0; i < 16; i++) fmap[i] = 4'(i + 1);
`ifdef GNR_TIMEOUT_EN
        run_job(4'd0, 16, 0, 1, 18, 0);
`else
        run_job(4'd0, 32, 16, 0, 51, 0);
`endif

        // asynchronous reset in the middle of RUN; init_valid must be ignored while busy
        @(negedge clk);
        init_valid = 1'b1;
        init_state = 4'd3;
        @(negedge clk);
        init_state = 4'd7;
        #1 chk("busy_init_ready", 32'(init_ready), 0);
        @(negedge clk);
        #1 chk("run_init_ready", 32'(init_ready), 0);
        chk("run_start_s1", 32'(start_s1), 1);
        init_valid = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1 chk("rst_outs", 32'({init_ready, reset_nos, init_out, start_s0, start_s1,
                                busy, out_valid, out_timeout}), 0);
        chk("rst_meet", 32'(out_meet), 0);
        chk("rst_period", 32'(out_period), 0);
        @(negedge clk);
        rst = 1'b0;

        // clear during PERIOD of the 3-cycle orbit (offset 9 from LOAD)
        set_identity();
        fmap[1] = 4'd2; fmap[2] = 4'd3; fmap[3] = 4'd1;
        @(negedge clk);
        init_valid = 1'b1;
        init_state = 4'd1;
        @(negedge clk);
        init_valid = 1'b0;
        for (int i = 0; i < 9; i++) @(negedge clk);
        chk("period_start_s0", 32'(start_s0), 0);
        chk("period_busy", 32'(busy), 1);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("clear_busy", 32'(busy), 0);
        chk("clear_start_s1", 32'(start_s1), 0);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("clear_no_valid", 32'(seen), 0);

        // new job after reset and clear
        run_job(4'd1, 6, 3, 0, 12, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
